// File: rtl/serial_word_collector_pkg.sv
// Shared constants for the serial word collector: default frame length, output
// buffer state encoding and the overflow counter width.
package serial_word_collector_pkg;

    localparam int WORD_W_DEF = 4;
    localparam int OVF_CNT_W  = 8;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'b00,
        FIFO_ONE   = 2'b01,
        FIFO_FULL  = 2'b10
    } fifo_state_e;

    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (v == OVF_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/serial_word_collector_if.sv
// Parallel word handshake between the collector (master) and its consumer (slave).
interface serial_word_collector_if
    import serial_word_collector_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic [WORD_W-1:0] word_data;
    logic              word_ovf;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, word_ovf, word_valid, input  word_ready);
    modport slave  (input  word_data, word_ovf, word_valid, output word_ready);
endinterface

// File: rtl/serial_word_collector_word_fifo2.sv
// Two-entry FIFO. The head register only changes on a push or on a pop from FULL,
// so the last popped entry stays on dout_o while the buffer is empty.
module word_fifo2
    import serial_word_collector_pkg::*;
#(
    parameter int W = WORD_W_DEF + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         ready_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic         full_o,
    output logic         drop_o
);
    fifo_state_e  state_q, state_d;
    logic [W-1:0] head_q, tail_q;
    logic         pop;

    assign pop    = (state_q != FIFO_EMPTY) && ready_i;
    assign dout_o = head_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FIFO_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FIFO_EMPTY: if (push_i)          state_d = FIFO_ONE;
            FIFO_ONE: begin
                if (push_i && !pop)          state_d = FIFO_FULL;
                else if (pop && !push_i)     state_d = FIFO_EMPTY;
            end
            FIFO_FULL:  if (pop && !push_i)  state_d = FIFO_ONE;
            default:                         state_d = FIFO_EMPTY;
        endcase
    end

    always_comb begin
        valid_o = (state_q != FIFO_EMPTY);
        full_o  = (state_q == FIFO_FULL);
        drop_o  = push_i && full_o && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (state_q)
                FIFO_EMPTY: if (push_i) head_q <= din_i;
                FIFO_ONE: begin
                    if (push_i && pop)  head_q <= din_i;
                    else if (push_i)    tail_q <= din_i;
                end
                FIFO_FULL: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push_i) tail_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial bits into words tagged with an overflow flag.
// Define SERIAL_COLLECT_OVF_CNT_EN to build the saturating overflow-word counter.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bit_en_i,
    input  logic                   s_bit_i,
    input  logic                   v_bit_i,
    serial_word_collector_if.master word_if,
    output logic                   drop_o,
    output logic                   overrun_o,
    output logic [OVF_CNT_W-1:0]   ovf_cnt_o
);
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    if (FIFO_DEPTH != 2) begin : g_bad_depth
        $error("serial_word_collector supports only FIFO_DEPTH == 2");
    end

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic              drop_q, overrun_q;
    logic              push, last_bit, fifo_drop, fifo_full;
    logic [WORD_W:0]   push_word, fifo_dout;

    assign last_bit  = (bit_cnt_q == CNT_W'(WORD_W - 1));
    // The completing bit bypasses the shift register so the word is pushed on that same edge.
    assign push_word = {ovf_acc_q | v_bit_i, s_bit_i, shreg_q[WORD_W-2:0]};

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ovf_acc_d = ovf_acc_q;
        push      = 1'b0;
        if (bit_en_i) begin
            shreg_d[bit_cnt_q] = s_bit_i;
            if (last_bit) begin
                bit_cnt_d = '0;
                ovf_acc_d = 1'b0;
                push      = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                ovf_acc_d = ovf_acc_q | v_bit_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ovf_acc_q <= 1'b0;
            drop_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ovf_acc_q <= ovf_acc_d;
            drop_q    <= fifo_drop;
            overrun_q <= overrun_q | fifo_drop;
        end
    end

    word_fifo2 #(.W(WORD_W + 1)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_word),
        .ready_i (word_if.word_ready),
        .dout_o  (fifo_dout),
        .valid_o (word_if.word_valid),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

    assign word_if.word_data = fifo_dout[WORD_W-1:0];
    assign word_if.word_ovf  = fifo_dout[WORD_W];
    assign drop_o            = drop_q;
    assign overrun_o         = overrun_q;

`ifdef SERIAL_COLLECT_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;
    always_ff @(posedge clk) begin
        if (rst)                                    ovf_cnt_q <= '0;
        else if (push && !fifo_drop && push_word[WORD_W]) ovf_cnt_q <= sat_inc(ovf_cnt_q);
    end
    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

    logic unused_full;
    assign unused_full = fifo_full;
endmodule
